// File: rtl/alu_issue_seq_if.sv
// Instruction handshake and ALU operand/result bus of the issue sequencer.
// master: the sequencer. It accepts instructions, drives the ALU operands and
//         reads the ALU result back.
// slave:  the environment. It is the instruction source together with the
//         combinational ALU.
interface alu_issue_seq_if;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [3:0]  alu_opext;
    logic [15:0] alu_s;
    logic [4:0]  alu_clfzn;

    modport master (
        input  inst_valid, inst, alu_s, alu_clfzn,
        output inst_ready, alu_a, alu_b, alu_opcode, alu_opext
    );

    modport slave (
        output inst_valid, inst, alu_s, alu_clfzn,
        input  inst_ready, alu_a, alu_b, alu_opcode, alu_opext
    );
endinterface

// File: rtl/alu_issue_seq.sv
// Multi-cycle issue sequencer for a CR16-style ALU.
// Each instruction reads the register file, drives the ALU, captures the
// result, then writes it back and updates the PSR.
// Optional build macro ALU_RESULT_REG_EN adds a CAP state. CAP registers the
// ALU result a second time, so latency grows from 3 to 4 cycles.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for an instruction; latch it on valid
// READ   | decode, read operands from the register file, register them
// EXEC   | ALU inputs stable; capture S and flags at end of cycle
// CAP    | second result register stage (ALU_RESULT_REG_EN only)
// WB     | write S to Rdest, update psr, pulse done
module alu_issue_seq #(
    parameter int NREGS = 16,
    parameter int DW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_issue_seq_if.master     bus,
    output logic [4:0]          psr,
    output logic                done,
    input  logic [3:0]          dbg_addr,
    output logic [DW-1:0]       dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_CAP  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   inst_q, inst_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [3:0]    opcode_q, opcode_d;
    logic [3:0]    opext_q, opext_d;
    logic [DW-1:0] res_s_q, res_s_d;
    logic [4:0]    res_f_q, res_f_d;
    logic [4:0]    psr_q, psr_d;
    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];

    logic [3:0]    op, ext, rd, rs;
    logic          is_rtype, is_sext, is_nop, no_write;
    logic [DW-1:0] imm, op_a, op_b;
    logic [DW-1:0] wb_s;
    logic [4:0]    wb_f;

`ifdef ALU_RESULT_REG_EN
    logic [DW-1:0] cap_s_q, cap_s_d;
    logic [4:0]    cap_f_q, cap_f_d;

    assign wb_s = cap_s_q;
    assign wb_f = cap_f_q;
`else
    assign wb_s = res_s_q;
    assign wb_f = res_f_q;
`endif

    assign op  = inst_q[15:12];
    assign rd  = inst_q[11:8];
    assign ext = inst_q[7:4];
    assign rs  = inst_q[3:0];

    // Decode the latched instruction into operand selections and writeback class
    always_comb begin
        is_rtype = (op == 4'h0) || (op == 4'hA);
        is_sext  = (op == 4'h5) || (op == 4'h7) || (op == 4'h9) || (op == 4'hB);
        imm      = is_sext ? {{(DW-8){inst_q[7]}}, inst_q[7:0]} : {{(DW-8){1'b0}}, inst_q[7:0]};
        is_nop   = (op == 4'h0) && (ext == 4'h0);
        no_write = is_nop || ((op == 4'h0) && (ext == 4'hB)) || (op == 4'hB)
                   || ((op == 4'hA) && (ext == 4'h2));
        // MOVI passes the immediate through A; MOV passes Rsrc through A
        if (op == 4'hD)
            op_a = imm;
        else if ((op == 4'h0) && (ext == 4'hD))
            op_a = regs_q[rs];
        else
            op_a = regs_q[rd];
        op_b = is_rtype ? regs_q[rs] : imm;
    end

    // Next-state, operand/result capture and register-file writeback
    always_comb begin
        state_d  = state_q;
        inst_d   = inst_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        opcode_d = opcode_q;
        opext_d  = opext_q;
        res_s_d  = res_s_q;
        res_f_d  = res_f_q;
        psr_d    = psr_q;
        regs_d   = regs_q;
`ifdef ALU_RESULT_REG_EN
        cap_s_d  = cap_s_q;
        cap_f_d  = cap_f_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.inst_valid) begin
                    inst_d  = bus.inst;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                alu_a_d  = op_a;
                alu_b_d  = op_b;
                opcode_d = op;
                opext_d  = ext;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                res_s_d = bus.alu_s;
                res_f_d = bus.alu_clfzn;
`ifdef ALU_RESULT_REG_EN
                state_d = S_CAP;
`else
                state_d = S_WB;
`endif
            end
`ifdef ALU_RESULT_REG_EN
            S_CAP: begin
                cap_s_d = res_s_q;
                cap_f_d = res_f_q;
                state_d = S_WB;
            end
`endif
            S_WB: begin
                if (!no_write)
                    regs_d[rd] = wb_s;
                if (!is_nop)
                    psr_d = wb_f;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand, result and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            inst_q   <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            opcode_q <= '0;
            opext_q  <= '0;
            res_s_q  <= '0;
            res_f_q  <= '0;
            psr_q    <= '0;
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            opcode_q <= opcode_d;
            opext_q  <= opext_d;
            res_s_q  <= res_s_d;
            res_f_q  <= res_f_d;
            psr_q    <= psr_d;
            regs_q   <= regs_d;
        end
    end

`ifdef ALU_RESULT_REG_EN
    // Second result stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_s_q <= '0;
            cap_f_q <= '0;
        end else begin
            cap_s_q <= cap_s_d;
            cap_f_q <= cap_f_d;
        end
    end
`endif

    assign bus.inst_ready = (state_q == S_IDLE);
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = opcode_q;
    assign bus.alu_opext  = opext_q;
    assign psr            = psr_q;
    assign done           = (state_q == S_WB);
    assign dbg_data       = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq. A behavioural ALU drives alu_s/alu_clfzn.
// A reference model tracks the register file and the psr from the
// instruction rules.
module tb_alu_issue_seq;

`ifdef ALU_RESULT_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        rst_n;
    logic [4:0]  psr;
    logic        done;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    alu_issue_seq_if bus ();

    alu_issue_seq #(.NREGS(16), .DW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.master),
        .psr      (psr),
        .done     (done),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_err;
    int          acc_cnt;
    int          cyc;
    int          done_q[$];
    logic [15:0] m_reg [16];
    logic [4:0]  m_psr;
    logic [15:0] last_b;

    // Behavioural ALU: returns {S, C, L, F, Z, N}
    function automatic logic [20:0] alu_f(input logic [3:0] op, input logic [3:0] ext,
                                          input logic [15:0] a, input logic [15:0] b);
        logic [3:0]  fn;
        logic [16:0] w;
        logic [15:0] s;
        logic        c, l, f;
        fn = (op == 4'h0 || op == 4'hA) ? ext : op;
        c = 1'b0; l = 1'b0; f = 1'b0;
        case (fn)
            4'h5, 4'h6: begin
                w = {1'b0, a} + {1'b0, b};
                s = w[15:0]; c = w[16];
                f = (a[15] == b[15]) && (s[15] != a[15]);
            end
            4'h9, 4'hB: begin
                w = {1'b0, a} - {1'b0, b};
                s = w[15:0]; c = w[16];
                f = (a[15] != b[15]) && (s[15] != a[15]);
                l = (a < b);
            end
            4'h1:    s = a & b;
            4'h2:    s = a | b;
            4'h3:    s = a ^ b;
            4'hD:    s = a;
            default: s = b;
        endcase
        return {s, c, l, f, (s == 16'h0000), s[15]};
    endfunction

    always_comb begin
        {bus.alu_s, bus.alu_clfzn} = alu_f(bus.alu_opcode, bus.alu_opext, bus.alu_a, bus.alu_b);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.inst_valid && bus.inst_ready) acc_cnt++;
        if (done) done_q.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one instruction to the architectural model. The operands are read
    // before anything is written, so Rdest==Rsrc sees the old value.
    task automatic model_exec(input logic [15:0] w, output logic [15:0] ea, output logic [15:0] eb);
        logic [3:0]  op, rd, ext, rs;
        logic [15:0] imm;
        logic [20:0] r;
        logic        nop, nowr;
        op = w[15:12]; rd = w[11:8]; ext = w[7:4]; rs = w[3:0];
        if (op == 4'h5 || op == 4'h7 || op == 4'h9 || op == 4'hB)
            imm = 16'($signed(w[7:0]));
        else
            imm = {8'h00, w[7:0]};
        if (op == 4'hD)                     ea = imm;
        else if (op == 4'h0 && ext == 4'hD) ea = m_reg[rs];
        else                                ea = m_reg[rd];
        eb = (op == 4'h0 || op == 4'hA) ? m_reg[rs] : imm;
        r = alu_f(op, ext, ea, eb);
        nop  = (op == 4'h0 && ext == 4'h0);
        nowr = nop || (op == 4'h0 && ext == 4'hB) || op == 4'hB || (op == 4'hA && ext == 4'h2);
        if (!nowr) m_reg[rd] = r[20:5];
        if (!nop)  m_psr = r[4:0];
    endtask

    // Present w until it is accepted, then drive nv/nw as the next source word.
    // The task checks timing, operands and writeback, and returns in the low
    // phase of the first IDLE cycle after writeback.
    task automatic issue(input logic [15:0] w, input logic nv, input logic [15:0] nw);
        logic [15:0] ea, eb;
        int          n;
        bus.inst = w;
        bus.inst_valid = 1'b1;
        n = 0;
        while (!bus.inst_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1 bus.inst_valid = nv;
        bus.inst = nw;
        model_exec(w, ea, eb);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("busy_ready", 32'(bus.inst_ready), 32'd0);
            chk("done_timing", 32'(done), 32'(k == LAT));
            if (k == 2) begin
                chk("exec_a", 32'(bus.alu_a), 32'(ea));
                chk("exec_b", 32'(bus.alu_b), 32'(eb));
                chk("exec_opcode", 32'(bus.alu_opcode), 32'(w[15:12]));
                chk("exec_opext", 32'(bus.alu_opext), 32'(w[7:4]));
                last_b = bus.alu_b;
            end
        end
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_ready", 32'(bus.inst_ready), 32'd1);
        chk("psr", 32'(psr), 32'(m_psr));
        dbg_addr = w[11:8];
        #1 chk("wb_rdest", 32'(dbg_data), 32'(m_reg[w[11:8]]));
    endtask

    task automatic dump_check();
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1 chk("regfile", 32'(dbg_data), 32'(m_reg[i]));
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
        m_psr = 5'd0;
    endtask

    initial begin
        int acc0;
        n_cmp = 0; n_err = 0; acc_cnt = 0; cyc = 0; last_b = 16'h0000;
        bus.inst_valid = 1'b0; bus.inst = 16'h0000; dbg_addr = 4'h0; rst_n = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.inst_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_psr", 32'(psr), 32'd0);
        chk("rst_a", 32'(bus.alu_a), 32'd0);
        chk("rst_b", 32'(bus.alu_b), 32'd0);
        chk("rst_opcode", 32'(bus.alu_opcode), 32'd0);
        chk("rst_opext", 32'(bus.alu_opext), 32'd0);
        dump_check();
        rst_n = 1'b1;
        @(negedge clk);

        // reset asserted while an ADDI on R1 is in EXEC
        issue(16'hD105, 1'b0, 16'h0000);
        chk("seed_r1", 32'(dbg_data), 32'h0005);
        bus.inst = 16'h5101; bus.inst_valid = 1'b1;
        @(posedge clk);
        #1 bus.inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus.inst_ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_psr", 32'(psr), 32'd0);
        chk("midrst_a", 32'(bus.alu_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        dbg_addr = 4'h1;
        #1 chk("midrst_r1", 32'(dbg_data), 32'h0000);
        dump_check();

        // MOVI R1,0x7F; MOVI R2,0x01; ADD R1,R2
        issue(16'hD17F, 1'b0, 16'h0000);
        issue(16'hD201, 1'b0, 16'h0000);
        issue(16'h0152, 1'b0, 16'h0000);
        chk("add_r1", 32'(dbg_data), 32'h0080);
        chk("add_c", 32'(psr[4]), 32'd0);
        chk("add_f", 32'(psr[2]), 32'd0);

        // MOVI R3,0xFF zero-extends; ADDI R3,0xFF sign-extends
        issue(16'hD3FF, 1'b0, 16'h0000);
        chk("movi_r3", 32'(dbg_data), 32'h00FF);
        issue(16'h53FF, 1'b0, 16'h0000);
        chk("addi_b", 32'(last_b), 32'hFFFF);
        chk("addi_r3", 32'(dbg_data), 32'h00FE);
        chk("addi_c", 32'(psr[4]), 32'd1);

        // CMP R1,R1 then NOP
        issue(16'h01B1, 1'b0, 16'h0000);
        chk("cmp_r1", 32'(dbg_data), 32'h0080);
        chk("cmp_z", 32'(psr[1]), 32'd1);
        issue(16'h0000, 1'b0, 16'h0000);
        chk("nop_z", 32'(psr[1]), 32'd1);
        dump_check();

        // back-to-back stream with inst_valid held high
        done_q.delete();
        acc0 = acc_cnt;
        issue(16'hD412, 1'b1, 16'h0451);
        issue(16'h0451, 1'b1, 16'h0494);
        issue(16'h0494, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        chk("stream_accepts", 32'(acc_cnt - acc0), 32'd3);
        chk("stream_dones", 32'(done_q.size()), 32'd3);
        if (done_q.size() == 3) begin
            chk("stream_gap1", 32'(done_q[1] - done_q[0]), 32'(LAT + 1));
            chk("stream_gap2", 32'(done_q[2] - done_q[1]), 32'(LAT + 1));
        end
        dump_check();

        // random instruction words against the model
        for (int t = 0; t < 40; t++) begin
            issue(16'($urandom), 1'b0, 16'h0000);
            if (t % 10 == 9) dump_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Multi-cycle issue sequencer on the producer side of the ALU interface.
- Accepts 16-bit CR16-style instruction words, reads a 16x16 register file, and drives A/B/opcode/opext into the combinational ALU.
- Captures S and CLFZN from the ALU, writes S back to the register file and latches the flags into a processor status register (PSR).
- Sits between the instruction source and the ALU in the datapath.

Parameters:
- NREGS, 16, number of general registers; must be 16 (4-bit register fields).
- DW, 16, datapath width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid  in  1  instruction word present.
- inst_ready  out  1  sequencer can accept an instruction.
- inst  in  16  instruction: [15:12] opcode, [11:8] Rdest, [7:4] opext/imm_hi, [3:0] Rsrc/imm_lo.
- alu_a  out  16  ALU operand A.
- alu_b  out  16  ALU operand B.
- alu_opcode  out  4  ALU opcode.
- alu_opext  out  4  ALU opcode extension.
- alu_s  in  16  ALU result.
- alu_clfzn  in  5  ALU flags {C,L,F,Z,N}.
- psr  out  5  latched flags.
- done  out  1  one-cycle pulse when an instruction retires.
- dbg_addr  in  4  debug register-file read address.
- dbg_data  out  16  register-file contents at dbg_addr, combinational.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all registers R0..R15=0, psr=0, alu_a/alu_b/alu_opcode/alu_opext=0, done=0, inst_ready=1.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - inst_ready=1.
  - On inst_valid&&inst_ready, latch inst, go to READ. Otherwise stay in IDLE.
- READ:
  - alu_opcode=inst[15:12].
  - alu_opext=inst[7:4] for R-type (opcode 0000 or 1010); otherwise alu_opext=inst[7:4] as well, since the ALU ignores it for I-type.
  - Operand A:
    - R-type: A=R[Rdest].
    - I-type: A=R[Rdest].
    - Exception for MOV (0000_1101): A=R[Rsrc].
    - Exception for MOVI (1101): A=imm.
  - Operand B:
    - R-type: B=R[Rsrc].
    - I-type: B=imm.
  - Immediate: imm=inst[7:0], sign-extended for opcodes 0101, 0111, 1001, 1011; zero-extended otherwise.
  - Operands are registered; go to EXEC.
- EXEC:
  - ALU inputs stable for this whole cycle.
  - Capture alu_s and alu_clfzn at the end of the cycle; go to WB.
- WB:
  - Write captured S to R[Rdest] unless the op is NOP (opcode 0000, opext 0000), CMP (0000_1011), CMPI (1011), or CMPU/I (1010_0010).
  - psr <= captured flags for every op except NOP; NOP leaves psr unchanged.
  - done=1 for exactly this cycle; go to IDLE.
- Latency: accept edge to done = 3 cycles. Throughput: one instruction per 4 cycles.
- inst_ready=0 in READ, EXEC and WB. inst_valid is ignored outside IDLE; the source must hold inst until accepted.
- Rdest==Rsrc is legal: operands are read in READ, before writeback.
- R0 is an ordinary writable register.
- Writes wrap modulo 2^16; the sequencer applies no arithmetic of its own.
- dbg_data reflects the write on the cycle after WB.
- rst_n asserted mid-instruction: the instruction is abandoned with no register or psr write; the block returns to reset values immediately.

Optional Feature:
- Macro: ALU_RESULT_REG_EN.
- Defined:
  - An extra state CAP is inserted between EXEC and WB. EXEC holds the ALU inputs; CAP registers alu_s/alu_clfzn a second time for timing.
  - Latency = 4 cycles; inst_ready deasserts for 4 cycles.
- Undefined:
  - 3-cycle latency as above.
  - All other behaviour is identical in both builds.

Test Plan:
- Reset mid-EXEC with R1=5 seeded via MOVI R1,5 -> after rst_n release, dbg R1=0, psr=0, inst_ready=1, no done pulse.
- MOVI R1,0x7F; MOVI R2,0x01; ADD R1,R2 (0x0152) -> R1=0x0080, done 3 cycles after each accept, psr F=0 C=0.
- MOVI R3,0xFF -> R3=0x00FF (zero-extended); ADDI R3,0xFF (0x53FF) -> B=0xFFFF, R3=0x00FE, psr C=1.
- CMP R1,R1 with R1=0x0080 -> R1 unchanged, psr Z=1; then NOP (0x0000) -> psr still Z=1, no register written.
- Hold inst_valid=1 continuously with a 3-instruction stream -> exactly 3 accepts, inst_ready low in the 3 cycles after each accept, done pulses 4 cycles apart.
- Build with ALU_RESULT_REG_EN, rerun the ADD case -> same R1/psr values, done 4 cycles after accept.
